// File: rtl/conv_pkg.sv
// Shared constants and types for the 9x9 convolution engine and its frame serializer.
// Define CONV_SER_CROP_EN to stream only the interior window (border pixels dropped).
package conv_pkg;

    localparam int ROWS    = 9;
    localparam int COLS    = 9;
    localparam int PIX_W   = 8;
    localparam int FRAME_W = ROWS * COLS * PIX_W;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ser_state_t;

    // Border width removed from each edge; the zero-padded 3x3 kernel corrupts one pixel.
`ifdef CONV_SER_CROP_EN
    localparam int CROP = 1;
`else
    localparam int CROP = 0;
`endif

    localparam int R0 = CROP;
    localparam int R1 = ROWS - 1 - CROP;
    localparam int C0 = CROP;
    localparam int C1 = COLS - 1 - CROP;

endpackage

// File: rtl/conv_raster_cnt.sv
// Row/column raster counter over a window [R0..R1] x [C0..C1] with sof/eol/last flags.
// i_start loads the window origin; i_adv steps one pixel and wraps to the origin after the last.
module conv_raster_cnt
    import conv_pkg::*;
#(
    parameter int RW = 4,
    parameter int CW = 4,
    parameter int R0 = 0,
    parameter int R1 = 8,
    parameter int C0 = 0,
    parameter int C1 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_adv,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_sof,
    output logic          o_eol,
    output logic          o_last
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_eol;
    logic          w_last;

    assign w_eol  = (r_col == CW'(C1));
    assign w_last = w_eol && (r_row == RW'(R1));

    // Wrapping on the last pixel keeps the index inside the frame at all times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_start) begin
            r_row <= RW'(R0);
            r_col <= CW'(C0);
        end else if (i_adv) begin
            if (w_last) begin
                r_row <= RW'(R0);
                r_col <= CW'(C0);
            end else if (w_eol) begin
                r_row <= r_row + RW'(1);
                r_col <= CW'(C0);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_sof  = (r_row == RW'(R0)) && (r_col == CW'(C0));
    assign o_eol  = w_eol;
    assign o_last = w_last;

endmodule

// File: rtl/conv_frame_serializer.sv
// Captures a packed convolution result frame and streams it one pixel per cycle in raster order.
// Build option CONV_SER_CROP_EN (via conv_pkg) restricts the stream to the interior window.
module conv_frame_serializer #(
    parameter int ROWS  = conv_pkg::ROWS,
    parameter int COLS  = conv_pkg::COLS,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       img_valid,
    input  logic [ROWS*COLS*PIX_W-1:0] img_data,
    output logic                       img_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PIX_W-1:0]           m_data,
    output logic                       m_sof,
    output logic                       m_eol,
    output logic                       m_last,
    output logic                       busy,
    output logic                       drop,
    output conv_pkg::ser_state_t       dbg_state
);
    import conv_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
    // data and markers stable while valid is high and ready is low.
    localparam int FW    = ROWS * COLS * PIX_W;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam int OFF_W = $clog2(FW);
    localparam int LR0   = CROP;
    localparam int LR1   = ROWS - 1 - CROP;
    localparam int LC0   = CROP;
    localparam int LC1   = COLS - 1 - CROP;

    ser_state_t      r_state;
    ser_state_t      w_state_nxt;
    logic [FW-1:0]   r_frame;
    logic            r_drop;
    logic            w_capture;
    logic            w_beat;
    logic            w_streaming;
    logic [RW-1:0]   w_row;
    logic [CW-1:0]   w_col;
    logic            w_sof;
    logic            w_eol;
    logic            w_last;
    logic [IDX_W-1:0] w_pix_idx;
    logic [OFF_W-1:0] w_off;

    assign w_streaming = (r_state == S_STREAM);
    assign img_ready   = (r_state == S_IDLE);
    assign w_capture   = img_valid && img_ready;
    assign w_beat      = w_streaming && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (img_valid) w_state_nxt = S_STREAM;
            S_STREAM: if (m_ready && w_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // The frame register only loads on capture, so later img_data activity is invisible.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_frame <= img_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (img_valid && !img_ready) begin
            r_drop <= 1'b1;
        end
    end

    conv_raster_cnt #(
        .RW (RW),
        .CW (CW),
        .R0 (LR0),
        .R1 (LR1),
        .C0 (LC0),
        .C1 (LC1)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_capture),
        .i_adv   (w_beat),
        .o_row   (w_row),
        .o_col   (w_col),
        .o_sof   (w_sof),
        .o_eol   (w_eol),
        .o_last  (w_last)
    );

    assign w_pix_idx = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
    assign w_off     = OFF_W'(w_pix_idx) * OFF_W'(PIX_W);

    // Data and markers read as zero outside STREAM so idle counter values never leak out.
    assign m_valid   = w_streaming;
    assign m_data    = w_streaming ? r_frame[w_off +: PIX_W] : '0;
    assign m_sof     = w_streaming && w_sof;
    assign m_eol     = w_streaming && w_eol;
    assign m_last    = w_streaming && w_last;
    assign busy      = w_streaming;
    assign drop      = r_drop;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_frame_serializer.sv
// Directed bench for conv_frame_serializer: full frame, backpressure, overrun, reset, back-to-back.
// Expected beats come from pixel (i,j) = 3*i+j+3 over the streamed window.
module tb_conv_frame_serializer;
    import conv_pkg::*;

    localparam int FW = ROWS * COLS * PIX_W;
`ifdef CONV_SER_CROP_EN
    localparam int BR0 = 1, BR1 = 7, BC0 = 1, BC1 = 7;
    localparam int FIRST_PIX = 7;
`else
    localparam int BR0 = 0, BR1 = 8, BC0 = 0, BC1 = 8;
    localparam int FIRST_PIX = 3;
`endif
    localparam int NB     = (BR1 - BR0 + 1) * (BC1 - BC0 + 1);
    localparam int BUDGET = 400;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          img_valid = 1'b0;
    logic [FW-1:0] img_data  = '0;
    logic          img_ready;
    logic          m_valid;
    logic          m_ready   = 1'b0;
    logic [PIX_W-1:0] m_data;
    logic          m_sof, m_eol, m_last, busy, drop;
    ser_state_t    dbg_state;

    conv_frame_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .img_valid (img_valid),
        .img_data  (img_data),
        .img_ready (img_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .m_last    (m_last),
        .busy      (busy),
        .drop      (drop),
        .dbg_state (dbg_state)
    );

    // scoreboard: {sof, eol, last, data}
    logic [PIX_W+2:0] exp_q[$];
    logic [FW-1:0]    frame_pat;
    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] build_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                f[(i*COLS+j)*PIX_W +: PIX_W] = PIX_W'(3*i + j + 3);
        return f;
    endfunction

    task automatic fill_exp();
        exp_q.delete();
        for (int r = BR0; r <= BR1; r++)
            for (int c = BC0; c <= BC1; c++)
                exp_q.push_back({(r == BR0 && c == BC0), (c == BC1), (r == BR1 && c == BC1),
                                 PIX_W'(3*r + c + 3)});
    endtask

    // driver: present the frame for one edge, then scramble img_data
    task automatic start_frame();
        fill_exp();
        m_ready   = 1'b1;
        img_data  = frame_pat;
        img_valid = 1'b1;
        @(posedge clk); #1;
        img_valid = 1'b0;
        img_data  = ~frame_pat;
        chk("cap_valid", m_valid, 1);
        chk("cap_busy", busy, 1);
        chk("cap_ready", img_ready, 0);
    endtask

    // driver + monitor for one streamed frame; stops when m_valid drops or at stop_beat
    task automatic run_stream(input int stall_beat, input int stall_len, input int pulse_beat,
                              input int stop_beat, input bit keep_valid,
                              output int beats, output int cycles);
        int stalled;
        logic [PIX_W+2:0] obs;
        logic [PIX_W+2:0] held;
        beats   = 0;
        cycles  = 0;
        stalled = 0;
        held    = '0;
        while (cycles < BUDGET) begin
            if (!m_valid || beats == stop_beat) break;
            obs = {m_sof, m_eol, m_last, m_data};
            img_valid = keep_valid || (beats == pulse_beat);
            if (beats == stall_beat && stalled < stall_len) begin
                if (stalled == 0) held = obs;
                else chk("stall_hold", 32'(obs), 32'(held));
                if (exp_q.size() == 0) chk("stall_empty", 32'(exp_q.size()), 1);
                else chk("stall_data", 32'(obs), 32'(exp_q[0]));
                m_ready = 1'b0;
                stalled++;
            end else begin
                m_ready = 1'b1;
                if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 1);
                else chk($sformatf("beat%0d", beats), 32'(obs), 32'(exp_q.pop_front()));
                beats++;
            end
            @(posedge clk); #1;
            if (!keep_valid) img_valid = 1'b0;
            m_ready = 1'b1;
            cycles++;
        end
        if (cycles >= BUDGET) chk("timeout", cycles, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int beats, cycles;

    initial begin
        frame_pat = build_frame();
        do_reset();
        chk("rst_ready", img_ready, 1);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_marks", {m_sof, m_eol, m_last}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        chk("rst_state", dbg_state, S_IDLE);

        // full frame at one pixel per cycle
        start_frame();
        chk("first_pix", m_data, FIRST_PIX);
        chk("first_sof", m_sof, 1);
        chk("stream_state", dbg_state, S_STREAM);
        run_stream(-1, 0, -1, -1, 1'b0, beats, cycles);
        chk("full_beats", beats, NB);
        chk("full_cycles", cycles, NB);
        chk("full_left", exp_q.size(), 0);
        chk("full_ready_after", img_ready, 1);
        chk("full_valid_after", m_valid, 0);
        chk("full_drop", drop, 0);

        // backpressure for 5 cycles at beat 10
        start_frame();
        run_stream(9, 5, -1, -1, 1'b0, beats, cycles);
        chk("bp_beats", beats, NB);
        chk("bp_cycles", cycles, NB + 5);
        chk("bp_left", exp_q.size(), 0);

        // overrun at beat 40
        start_frame();
        run_stream(-1, 0, 39, -1, 1'b0, beats, cycles);
        chk("ovr_beats", beats, NB);
        chk("ovr_drop", drop, 1);
        @(posedge clk); #1;
        chk("ovr_no_capture", m_valid, 0);
        chk("ovr_drop_sticky", drop, 1);

        // reset at beat 20, then a clean restart
        start_frame();
        run_stream(-1, 0, -1, 19, 1'b0, beats, cycles);
        chk("mid_beats", beats, 19);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_valid", m_valid, 0);
        chk("mid_ready", img_ready, 1);
        chk("mid_last", m_last, 0);
        chk("mid_drop", drop, 0);
        start_frame();
        chk("restart_pix", m_data, FIRST_PIX);
        run_stream(-1, 0, -1, -1, 1'b0, beats, cycles);
        chk("restart_beats", beats, NB);

        // img_valid on the same edge as the final beat
        start_frame();
        run_stream(-1, 0, NB - 1, -1, 1'b0, beats, cycles);
        chk("fin_beats", beats, NB);
        chk("fin_drop", drop, 1);
        chk("fin_valid", m_valid, 0);
        @(posedge clk); #1;
        chk("fin_no_capture", m_valid, 0);

        // back-to-back with img_valid held high
        do_reset();
        fill_exp();
        m_ready   = 1'b1;
        img_data  = frame_pat;
        img_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_cap1", m_valid, 1);
        run_stream(-1, 0, -1, -1, 1'b1, beats, cycles);
        chk("b2b_beats1", beats, NB);
        chk("b2b_gap_ready", img_ready, 1);
        fill_exp();
        @(posedge clk); #1;
        img_valid = 1'b0;
        chk("b2b_cap2", m_valid, 1);
        chk("b2b_sof2", m_sof, 1);
        chk("b2b_pix2", m_data, FIRST_PIX);
        run_stream(-1, 0, -1, -1, 1'b0, beats, cycles);
        chk("b2b_beats2", beats, NB);
        chk("b2b_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_frame_serializer.md
# conv_frame_serializer

Output-side reader for the 9x9 convolution engine. Captures the flat packed result frame (same layout as the engine's image bus: pixel (r,c) at bits [(r*COLS+c)*PIX_W +: PIX_W]) when the engine signals completion. Streams it out one pixel per cycle in raster order over a valid/ready interface with frame and line markers. Sits between the convolution core and any downstream consumer such as a display, DMA or UART bridge.

## Interface
- ROWS, 9, frame height in pixels
- COLS, 9, frame width in pixels
- PIX_W, 8, bits per pixel
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- img_valid  in  1  frame available; connect to the engine's done
- img_data  in  ROWS*COLS*PIX_W  packed result frame; sampled only on capture
- img_ready  out  1  high in IDLE; capture occurs when img_valid && img_ready
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts pixel
- m_data  out  PIX_W  current pixel
- m_sof  out  1  first pixel of frame (qualified by m_valid)
- m_eol  out  1  last pixel of a row
- m_last  out  1  last pixel of frame
- busy  out  1  frame held or streaming
- drop  out  1  sticky: img_valid seen while img_ready low; cleared only by rst

## Operation
- States: IDLE, STREAM.
- IDLE: img_ready=1, m_valid=0. On img_valid: latch img_data into the frame register, set row=R0 and col=C0, go to STREAM.
- STREAM: m_valid=1. m_data = frame[(row*COLS+col)*PIX_W +: PIX_W]. On m_valid && m_ready:
  - if col==C1: col=C0, row++
  - otherwise: col++
  - on the beat where m_last is set, go to IDLE.
- Markers:
  - m_sof = (row==R0 && col==C0)
  - m_eol = (col==C1)
  - m_last = (row==R1 && col==C1)
- Bounds without crop: R0=C0=0, R1=ROWS-1, C1=COLS-1.
- Counters are $clog2(ROWS) and $clog2(COLS) bits wide. Index arithmetic is unsigned and never exceeds ROWS*COLS-1.
- img_valid in STREAM is ignored for capture and sets drop. The held frame is not overwritten.
- img_data changing after capture has no effect.

## Timing
- Reset values: img_ready=1, m_valid=0, m_data=0, m_sof=0, m_eol=0, m_last=0, busy=0, drop=0, row=col=0, state=IDLE.
- Capture at edge N: m_valid, busy and pixel (R0,C0) are visible after edge N. img_ready drops at the same time.
- Throughput is 1 pixel/cycle with m_ready held high. A full frame leaves in ROWS*COLS cycles, or (ROWS-2)*(COLS-2) with crop.
- Backpressure: while m_valid && !m_ready, m_data and all markers hold stable.
- Last beat accepted at edge M: after M, m_valid=0 and img_ready=1. A new capture is possible at edge M+1. The minimum frame-to-frame gap is 1 cycle.
- img_valid and the final m_ready arriving on the same edge: no capture, and drop is set, because img_ready was low at that edge.
- rst mid-frame: on the next edge, return to IDLE with all reset values. The partial frame is discarded and no m_last is emitted.

## Configuration
- CONV_SER_CROP_EN defined: only the interior is streamed, R0=C0=1, R1=ROWS-2, C1=COLS-2, giving 49 pixels for 9x9. This discards border outputs produced by the zero-padded 3x3 kernel. Markers refer to the cropped window.
- Not defined: the full ROWS*COLS frame is streamed.
- The handshake, latency and reset behaviour are identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - ROWS, COLS, PIX_W and FRAME_W = ROWS*COLS*PIX_W
  - the IDLE/STREAM state enum
  - the crop bounds R0/R1/C0/C1, derived under the macro
- The convolution core uses the same package constants for its buses.
- Sub-module conv_raster_cnt: row/col counter with advance input, configurable bounds, and sof/eol/last outputs. It is reusable by the input-side loader.

## Test plan
Frame pattern for all tests: pixel (i,j) = 3*i+j+3, so (0,0)=3, (0,8)=11, (8,8)=35, (1,1)=7, (7,7)=31.
- Full frame, m_ready=1: pulse img_valid -> 81 beats on consecutive cycles.
  - First beat m_data=3 with m_sof=1.
  - Beat 9 m_data=11 with m_eol=1.
  - Beat 81 m_data=35 with m_last=1.
  - img_ready=1 on the following cycle.
- Backpressure: hold m_ready=0 for 5 cycles at beat 10 -> m_data=6 (pixel (1,0)) stays stable. The stream resumes with no loss or duplication, 81 total beats.
- Overrun: pulse img_valid at beat 40 -> drop=1 and stays 1, the stream is unaffected, and the second frame is not captured.
- Reset mid-frame: assert rst at beat 20 for 1 cycle -> m_valid=0 and img_ready=1 after the edge. A new capture then restarts at m_data=3.
- Back-to-back frames: img_valid held high -> second capture 1 cycle after the first m_last. Frame 2 begins with m_sof=1 and m_data=3.
- CONV_SER_CROP_EN build: 49 beats, first m_data=7 with m_sof=1, first m_eol at m_data=13 (pixel (1,7)), m_last at m_data=31.
